// File: rtl/piso_shift_out_if.sv
// Load handshake and serial output bundle for piso_shift_out.
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high. The master holds load_valid and load_data stable
// until that edge. load_ready may depend combinationally on shift_enable,
// so the master must not make load_valid depend on load_ready.
interface piso_shift_out_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_enable;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output load_valid,
        output load_data,
        output shift_enable,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  shift_enable,
        output load_ready,
        output sout,
        output sout_valid,
        output frame_start,
        output frame_end,
        output busy
    );
endinterface

// File: rtl/piso_shift_out.sv
// Parallel-in serial-out transmitter. Takes a word over a valid/ready load
// port and shifts it out one bit per shift_enable strobe, flagging the
// first and last bit of each frame. A new word can be taken on the edge
// that consumes the last bit, giving gap-free back-to-back frames.
module piso_shift_out #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    piso_shift_out_if.slave     bus,
    output logic                state_dbg
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             load_ready_int;
    logic             accept;
    logic             out_bit;
    logic [WIDTH-1:0] shifted;

    // The link end of the register is the bit currently on sout.
    assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    // Ready when idle, or when the last bit is being consumed this edge.
    assign load_ready_int = !reset &&
                            ((state == IDLE) ||
                             (state == SHIFT && cnt == '0 && bus.shift_enable));
    assign accept    = bus.load_valid && load_ready_int;
    assign state_dbg = state;

    // State register: synchronous reset clears the frame outright.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic: load, shift on strobe, reload or retire at frame end.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_d = bus.load_data;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_enable) begin
                    if (cnt != '0) begin
                        shreg_d = shifted;
                        cnt_d   = cnt - CW'(1);
                    end else if (accept) begin
                        shreg_d = bus.load_data;
                        cnt_d   = CNT_MAX;
                    end else begin
                        shreg_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: everything but load_ready comes straight from registers.
    always_comb begin
        bus.load_ready  = load_ready_int;
        bus.sout_valid  = (state == SHIFT);
        bus.busy        = (state == SHIFT);
        bus.sout        = (state == SHIFT) ? out_bit : 1'b0;
        bus.frame_start = (state == SHIFT) && (cnt == CNT_MAX);
        bus.frame_end   = (state == SHIFT) && (cnt == '0);
    end
endmodule

// File: tb/tb_piso_shift_out.sv
// Bench for piso_shift_out: an MSB-first and an LSB-first instance receive
// identical stimulus and are compared each cycle against a word/bits-left
// reference model.
module tb_piso_shift_out;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    logic state_dbg_m;
    logic state_dbg_l;

    piso_shift_out_if #(.WIDTH(WIDTH)) bus_m ();
    piso_shift_out_if #(.WIDTH(WIDTH)) bus_l ();

    piso_shift_out #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(bus_m), .state_dbg(state_dbg_m)
    );
    piso_shift_out #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(bus_l), .state_dbg(state_dbg_l)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the word in flight and how many of its bits remain.
    logic [WIDTH-1:0] cur_word;
    int               bits_left;
    int               checks;
    int               fails;
    int               accepts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver: apply inputs, check outputs mid-cycle, then advance model over the edge.
    task automatic step(input logic rst, input logic vld, input logic [WIDTH-1:0] dat,
                        input logic se);
        logic exp_ready;
        logic exp_busy;
        logic exp_sout_m;
        logic exp_sout_l;
        reset              = rst;
        bus_m.load_valid   = vld;
        bus_l.load_valid   = vld;
        bus_m.load_data    = dat;
        bus_l.load_data    = dat;
        bus_m.shift_enable = se;
        bus_l.shift_enable = se;
        #1;
        exp_busy   = (bits_left != 0);
        exp_ready  = !rst && (bits_left == 0 || (bits_left == 1 && se));
        exp_sout_m = exp_busy ? cur_word[bits_left-1] : 1'b0;
        exp_sout_l = exp_busy ? cur_word[WIDTH-bits_left] : 1'b0;
        chk("ready_m", 32'(bus_m.load_ready), 32'(exp_ready));
        chk("ready_l", 32'(bus_l.load_ready), 32'(exp_ready));
        chk("sout_m", 32'(bus_m.sout), 32'(exp_sout_m));
        chk("sout_l", 32'(bus_l.sout), 32'(exp_sout_l));
        chk("valid_m", 32'(bus_m.sout_valid), 32'(exp_busy));
        chk("busy_l", 32'(bus_l.busy), 32'(exp_busy));
        chk("start_m", 32'(bus_m.frame_start), 32'(bits_left == WIDTH));
        chk("end_l", 32'(bus_l.frame_end), 32'(bits_left == 1));
        chk("state_m", 32'(state_dbg_m), 32'(exp_busy));
        @(posedge clk);
        #1;
        if (rst) begin
            bits_left = 0;
        end else begin
            if (bits_left > 0 && se) bits_left--;
            if (vld && exp_ready) begin
                cur_word  = dat;
                bits_left = WIDTH;
                accepts++;
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] word;
        logic             vld;
        int               target;
        checks    = 0;
        fails     = 0;
        accepts   = 0;
        bits_left = 0;
        cur_word  = '0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles with a word offered: nothing accepted.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hFF, 1'b1);

        // 0xA5 with constant strobe, then one idle cycle.
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < WIDTH + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // 0xA5 with strobe one cycle in three: 24 busy cycles.
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 3 * WIDTH + 2; i++) step(1'b0, 1'b0, 8'h00, (i % 3) == 2);

        // Back-to-back 0xA5 then 0x3C with load_valid held.
        target = accepts + 2;
        while (accepts < target) begin
            word = (accepts == target - 2) ? 8'hA5 : 8'h3C;
            step(1'b0, 1'b1, word, 1'b1);
        end
        for (int i = 0; i < WIDTH + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Single-bit words expose bit order on both instances.
        step(1'b0, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        for (int i = 0; i < WIDTH + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset after three bits, then a full 0xC3 frame.
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < WIDTH + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with a word held until taken and rare resets.
        vld  = 1'b0;
        word = '0;
        for (int i = 0; i < 600; i++) begin
            if (!vld && $urandom_range(0, 2) == 0) begin
                vld  = 1'b1;
                word = 8'($urandom);
            end
            target = accepts;
            step($urandom_range(0, 79) == 0, vld, word, $urandom_range(0, 3) != 0);
            if (accepts != target) vld = 1'b0;
        end
        for (int i = 0; i < 4 * WIDTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/piso_shift_out.md
# piso_shift_out

Parallel-in, serial-out transmitter that accepts a parallel word through a valid/ready handshake and drives it out one bit per enabled cycle. It is the sending end of the serial link whose receiving end captures bits into latch/flop storage.
- Paces its output with an external bit-rate strobe.
- Flags the first and last bit of every frame.
- Supports gap-free back-to-back words.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- load_valid  input  1  load_data holds a word to transmit.
- load_data  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- load_ready  output  1  block can accept a word this cycle.
- shift_enable  input  1  bit-rate strobe; the current bit is consumed on a rising edge where this is high.
- sout  output  1  serial data; 0 when no frame is active.
- sout_valid  output  1  sout carries a frame bit.
- frame_start  output  1  sout carries the first bit of a frame.
- frame_end  output  1  sout carries the last bit of a frame.
- busy  output  1  frame in progress (equals sout_valid).

## Operation
- Registers:
  - shreg: WIDTH bits.
  - cnt: ceil(log2(WIDTH)) bits; number of bits remaining minus 1.
  - state: one bit, values IDLE and SHIFT.
- Reset is synchronous. While reset is high at an edge: state=IDLE, shreg=0, cnt=0. load_ready is forced to 0 combinationally while reset is high.
- Output values after reset: sout=0, sout_valid=0, frame_start=0, frame_end=0, busy=0, load_ready=1 from the first cycle reset is low.
- Accept condition: load_valid && load_ready.
- load_ready is 1 in either of these cases:
  - state=IDLE.
  - state=SHIFT && cnt==0 && shift_enable.
- IDLE:
  - sout_valid=0 and sout=0. shift_enable is ignored.
  - On accept: shreg<=load_data, cnt<=WIDTH-1, state<=SHIFT.
- SHIFT:
  - sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. sout_valid=1.
  - frame_start = (cnt==WIDTH-1). frame_end = (cnt==0).
  - shift_enable=0: hold everything. The current bit stays on sout.
  - shift_enable=1 and cnt!=0: shift shreg toward the output end with a 0 fill, then cnt<=cnt-1.
  - shift_enable=1 and cnt==0:
    - If accept occurs, reload shreg and cnt, and stay in SHIFT.
    - Otherwise go to IDLE with shreg<=0.
- load_valid while busy and not at the last consumed bit: no accept, no effect. The upstream holds its word until load_ready.
- load_data changing while not accepted has no effect.

## Timing
- Accept at edge N: the first bit is on sout from cycle N+1, with frame_start=1.
- Each bit is held until an edge with shift_enable=1. A frame therefore needs exactly WIDTH enabled cycles in SHIFT.
- shift_enable held at 1 constantly: bits appear on cycles N+1..N+WIDTH. frame_end is on cycle N+WIDTH, and busy=0 on cycle N+WIDTH+1 if no new word is accepted.
- Back-to-back: accept on the last bit's consuming edge. The next frame's first bit follows with zero idle cycles, so frame_end in cycle k is followed by frame_start in cycle k+1.
- shift_enable on the accept edge in IDLE does not consume a bit.
- Reset mid-frame: the frame is aborted with no partial completion. The next cycle is IDLE with sout=0, and the following load sends a full word.
- load_ready is combinational from state, cnt, shift_enable and reset. All other outputs depend only on registers.

## Test plan
- Reset: hold reset high 2 cycles with load_valid=1 and load_data=0xFF -> load_ready=0, sout=0, sout_valid=0, busy=0, and no frame afterwards until a new accept; load_ready=1 on the first cycle after release.
- WIDTH=8, MSB_FIRST=1, load 0xA5 at edge N, shift_enable constant 1 -> sout = 1,0,1,0,0,1,0,1 on cycles N+1..N+8; frame_start only on N+1; frame_end only on N+8; busy=0 on N+9.
- Same word with shift_enable high one cycle in three -> each bit held 3 cycles; same sequence; frame_end lasts 3 cycles; total 24 busy cycles.
- Back-to-back: load_valid held with 0xA5, then 0x3C presented after the first accept -> 0x3C is accepted on the edge consuming 0xA5's last bit; sout = 10100101 00111100 with no gap; load_ready=0 during all other SHIFT cycles.
- MSB_FIRST=0, load 0x01 -> sout = 1,0,0,0,0,0,0,0; then load 0x80 -> sout = 0,0,0,0,0,0,0,1.
- Reset asserted after 3 bits of 0xA5 -> the next cycle has sout_valid=0 and sout=0; a subsequent load of 0xC3 transmits all 8 bits, 1,1,0,0,0,0,1,1, with frame_start on its first bit.
